// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle add/sub/and/or/slt/nop plus iterative
// shift-add multiply and restoring divide (WIDTH steps each).
module alu_multicycle #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MULDIV_EN = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_div_by_zero,
  output logic             o_illegal
);

  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned CW  = $clog2(WIDTH + 1);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // {high, low} accumulator: product halves for mul, {remainder, quotient} for div
  logic [W2-1:0]    r_acc;
  logic [WIDTH-1:0] r_opb;
  logic [CW-1:0]    r_cnt;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_ovf;
  logic             r_div_by_zero;
  logic             r_illegal;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_lt;
  logic [WIDTH:0]   w_mul_sum;
  logic [W2-1:0]    w_mul_acc;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_sub;
  logic [W2-1:0]    w_div_acc;
  logic             w_muldiv_en;
  logic             w_div_last;

  logic             w_done;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_hi;
  logic             w_zero;
  logic             w_ovf;
  logic             w_dbz;
  logic             w_ill;
  logic [W2-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_opb_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  assign w_muldiv_en = (MULDIV_EN != 0);
  assign w_div_last  = (r_cnt == CW'(1));

  // Single-cycle arithmetic on the live operands
  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  assign w_lt   = ($signed(i_a) < $signed(i_b));

  // One shift-add step: conditionally add multiplicand to high half, shift right
  assign w_mul_sum = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // One restoring-division step: shift in next dividend bit, trial subtract
  assign w_div_sh  = r_acc[W2-1:WIDTH-1];
  assign w_div_sub = w_div_sh - {1'b0, r_opb};
  assign w_div_acc = w_div_sub[WIDTH] ? {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_div_sub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start && w_muldiv_en) begin
          if (i_op == OP_MUL) begin
            w_state_nxt = S_MUL;
          end else if ((i_op == OP_DIV) && (i_b != '0)) begin
            w_state_nxt = S_DIV;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_done    = 1'b0;
    w_res     = '0;
    w_hi      = '0;
    w_zero    = 1'b0;
    w_ovf     = 1'b0;
    w_dbz     = 1'b0;
    w_ill     = 1'b0;
    w_acc_nxt = r_acc;
    w_opb_nxt = r_opb;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_done = 1'b1;
          case (i_op)
            OP_ADD: begin
              w_res = w_sum;
              w_ovf = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
              w_res = w_diff;
              w_ovf = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_SLT: w_res = WIDTH'(w_lt);
            OP_MUL: begin
              if (w_muldiv_en) begin
                w_done    = 1'b0;
                w_acc_nxt = {{WIDTH{1'b0}}, i_a};
                w_opb_nxt = i_b;
                w_cnt_nxt = CW'(WIDTH);
              end else begin
                w_ill = 1'b1;
              end
            end
            OP_DIV: begin
              if (!w_muldiv_en) begin
                w_ill = 1'b1;
              end else if (i_b == '0) begin
                w_res = '1;
                w_hi  = i_a;
                w_dbz = 1'b1;
              end else begin
                w_done    = 1'b0;
                w_acc_nxt = {{WIDTH{1'b0}}, i_a};
                w_opb_nxt = i_b;
                w_cnt_nxt = CW'(WIDTH);
              end
            end
            default: ;
          endcase
          // nop reports no flags at all, including ZERO
          w_zero = (i_op != OP_NOP) && (w_res == '0);
        end
      end
      S_MUL, S_DIV: begin
        w_acc_nxt = (r_state == S_MUL) ? w_mul_acc : w_div_acc;
        w_cnt_nxt = r_cnt - CW'(1);
        if (w_div_last) begin
          w_done = 1'b1;
          w_res  = w_acc_nxt[WIDTH-1:0];
          w_hi   = w_acc_nxt[W2-1:WIDTH];
          w_zero = (w_acc_nxt[WIDTH-1:0] == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; results hold until the next completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc         <= '0;
      r_opb         <= '0;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
      r_result_hi   <= '0;
      r_zero        <= 1'b0;
      r_ovf         <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_illegal     <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_opb  <= w_opb_nxt;
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_done;
      if (w_done) begin
        r_result      <= w_res;
        r_result_hi   <= w_hi;
        r_zero        <= w_zero;
        r_ovf         <= w_ovf;
        r_div_by_zero <= w_dbz;
        r_illegal     <= w_ill;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_result      = r_result;
  assign o_result_hi   = r_result_hi;
  assign o_zero        = r_zero;
  assign o_ovf         = r_ovf;
  assign o_div_by_zero = r_div_by_zero;
  assign o_illegal     = r_illegal;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: 8-bit table/random scoreboard run, 32-bit
// mid-operation reset sequence, and a MULDIV_EN=0 instance.
module tb_alu_multicycle;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [7:0] hi;
    logic       zero;
    logic       ovf;
    logic       dbz;
    logic       ill;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       zero;
    logic       ovf;
    logic       dbz;
    logic       ill;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic rst_n   = 1'b1;
  logic rst32_n = 1'b1;

  // 8-bit, mul/div enabled
  logic       s_start = 1'b0;
  logic [2:0] s_op = '0;
  logic [7:0] s_a = '0, s_b = '0;
  logic       busy, done, zero, ovf, dbz, ill;
  logic [7:0] res, hi;

  // 32-bit, mul/div enabled
  logic        s32_start = 1'b0;
  logic [2:0]  s32_op = '0;
  logic [31:0] s32_a = '0, s32_b = '0;
  logic        busy32, done32, zero32, ovf32, dbz32, ill32;
  logic [31:0] res32, hi32;

  // 8-bit, mul/div removed
  logic       sn_start = 1'b0;
  logic [2:0] sn_op = '0;
  logic [7:0] sn_a = '0, sn_b = '0;
  logic       busyn, donen, zeron, ovfn, dbzn, illn;
  logic [7:0] resn, hin;

  alu_multicycle #(.WIDTH(8), .MULDIV_EN(1)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_op(s_op), .i_a(s_a), .i_b(s_b),
    .o_busy(busy), .o_done(done), .o_result(res), .o_result_hi(hi), .o_zero(zero),
    .o_ovf(ovf), .o_div_by_zero(dbz), .o_illegal(ill));

  alu_multicycle #(.WIDTH(32), .MULDIV_EN(1)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst32_n), .i_start(s32_start), .i_op(s32_op), .i_a(s32_a), .i_b(s32_b),
    .o_busy(busy32), .o_done(done32), .o_result(res32), .o_result_hi(hi32), .o_zero(zero32),
    .o_ovf(ovf32), .o_div_by_zero(dbz32), .o_illegal(ill32));

  alu_multicycle #(.WIDTH(8), .MULDIV_EN(0)) u_dutn (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(sn_start), .i_op(sn_op), .i_a(sn_a), .i_b(sn_b),
    .o_busy(busyn), .o_done(donen), .o_result(resn), .o_result_hi(hin), .o_zero(zeron),
    .o_ovf(ovfn), .o_div_by_zero(dbzn), .o_illegal(illn));

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] last_res = '0, last_hi = '0;
  logic [5:0] last_flags = '0;

  // Reference model for the 8-bit instance
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t m;
    logic [15:0] p;
    m = '{res: '0, hi: '0, zero: 1'b0, ovf: 1'b0, dbz: 1'b0, ill: 1'b0, cyc: 0};
    case (op)
      3'd0: begin m.res = a + b; m.ovf = (a[7] == b[7]) && (m.res[7] != a[7]); end
      3'd1: begin m.res = a - b; m.ovf = (a[7] != b[7]) && (m.res[7] != a[7]); end
      3'd2: m.res = a & b;
      3'd3: m.res = a | b;
      3'd4: m.res = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      3'd5: begin p = a * b; m.res = p[7:0]; m.hi = p[15:8]; end
      3'd6: begin
        if (b == 8'd0) begin m.res = 8'hFF; m.hi = a; m.dbz = 1'b1; end
        else begin m.res = a / b; m.hi = a % b; end
      end
      default: ;
    endcase
    m.zero = (op != 3'd7) && (m.res == 8'd0);
    return m;
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [7:0] b);
    return ((op == 3'd5) || ((op == 3'd6) && (b != 8'd0))) ? 9 : 1;
  endfunction

  // Scoreboard monitor for the 8-bit instance, plus hold check between DONEs
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (done) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL spurious_done cyc=%0d res=%h", cyc, res);
        end else begin
          mon_e = sb.pop_front();
          if (res !== mon_e.res || hi !== mon_e.hi || zero !== mon_e.zero || ovf !== mon_e.ovf ||
              dbz !== mon_e.dbz || ill !== mon_e.ill || busy !== 1'b0 || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL result cyc=%0d: got res=%h hi=%h z=%b o=%b d=%b i=%b busy=%b, want res=%h hi=%h z=%b o=%b d=%b i=%b at cyc=%0d",
                     cyc, res, hi, zero, ovf, dbz, ill, busy,
                     mon_e.res, mon_e.hi, mon_e.zero, mon_e.ovf, mon_e.dbz, mon_e.ill, mon_e.cyc);
          end
        end
        last_res   = res;
        last_hi    = hi;
        last_flags = {zero, ovf, dbz, ill, 2'b00};
      end else if (res !== last_res || hi !== last_hi || {zero, ovf, dbz, ill, 2'b00} !== last_flags) begin
        n_err++;
        $display("FAIL hold cyc=%0d: got res=%h hi=%h, want res=%h hi=%h", cyc, res, hi, last_res, last_hi);
      end
    end
  end

  // Drive one operation (called at a negedge), junk STARTs while busy
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input exp_t e);
    int guard;
    int nbusy;
    int lat;
    lat = latency(op, b);
    s_op = op; s_a = a; s_b = b; s_start = 1'b1;
    e.cyc = cyc + lat;
    sb.push_back(e);
    guard = 0;
    nbusy = 0;
    @(negedge clk);
    while (!done && guard < 40) begin
      if (busy) begin
        nbusy++;
        s_start = 1'b1;
        s_op = 3'($urandom);
        s_a  = 8'($urandom);
        s_b  = 8'($urandom);
      end else begin
        s_start = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    s_start = 1'b0;
    n_cmp++;
    if (guard >= 40 || nbusy != lat - 1) begin
      n_err++;
      $display("FAIL busy_cycles op=%0d: got %0d busy cycles (timeout=%0d), want %0d", op, nbusy, guard >= 40, lat - 1);
    end
  endtask

  // Full 32-bit multiply with timing and product check
  task automatic issue32(input logic [31:0] a, input logic [31:0] b);
    int t;
    int guard;
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    s32_op = 3'd5; s32_a = a; s32_b = b; s32_start = 1'b1;
    t = cyc;
    @(negedge clk);
    s32_start = 1'b0;
    guard = 0;
    while (!done32 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!done32 || cyc != t + 33 || {hi32, res32} !== p || busy32 !== 1'b0) begin
      n_err++;
      $display("FAIL mul32: got {hi,res}=%h at cyc=%0d busy=%b, want %h at cyc=%0d", {hi32, res32}, cyc, busy32, p, t + 33);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  vec_t tbl[16];
  exp_t e;
  int   t0;

  initial begin
    // Test-plan vectors first (order matters for back-to-back)
    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{3'd4, 8'hFF, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{3'd4, 8'h01, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd5, 8'd200, 8'd3, 8'h58, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{3'd6, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'd6, 8'h33, 8'h00, 8'hFF, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{3'd3, 8'hF0, 8'h0C, 8'hFC, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'd7, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{3'd5, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3'd6, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{3'd6, 8'h03, 8'h0A, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{3'd1, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Asynchronous reset with no clock edge involved
    #2 rst_n = 1'b0; rst32_n = 1'b0;
    #1;
    check("reset8_outputs", {16'h0, res, hi}, 32'h0);
    check("reset8_flags", {26'h0, busy, done, zero, ovf, dbz, ill}, 32'h0);
    check("reset32_outputs", res32 | hi32, 32'h0);
    check("resetn_flags", {26'h0, busyn, donen, zeron, ovfn, dbzn, illn}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst32_n = 1'b1;
    @(negedge clk);

    // Table vectors, issued back to back
    for (int i = 0; i < 16; i++) begin
      e = '{res: tbl[i].res, hi: tbl[i].hi, zero: tbl[i].zero, ovf: tbl[i].ovf,
            dbz: tbl[i].dbz, ill: tbl[i].ill, cyc: 0};
      issue(tbl[i].op, tbl[i].a, tbl[i].b, e);
    end

    // Random vectors against the model
    for (int i = 0; i < 30; i++) begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      rop = 3'($urandom);
      ra  = 8'($urandom);
      rb  = (i % 7 == 0) ? 8'h00 : 8'($urandom);
      issue(rop, ra, rb, model(rop, ra, rb));
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    // 32-bit: full multiply, then one interrupted by reset, then a clean one
    issue32(32'hDEADBEEF, 32'h12345679);
    @(negedge clk);
    s32_op = 3'd5; s32_a = 32'hFFFFFFFF; s32_b = 32'hFFFFFFFF; s32_start = 1'b1;
    @(negedge clk);
    s32_start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy32_before_reset", {31'h0, busy32}, 32'h1);
    rst32_n = 1'b0;
    #1;
    check("reset32_async_busy_done", {30'h0, busy32, done32}, 32'h0);
    check("reset32_async_result", res32, 32'h0);
    check("reset32_async_hi", hi32, 32'h0);
    check("reset32_async_flags", {28'h0, zero32, ovf32, dbz32, ill32}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset32_no_done", {31'h0, done32}, 32'h0);
    end
    rst32_n = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      check("after_release_no_done", {31'h0, done32}, 32'h0);
    end
    issue32(32'h89ABCDEF, 32'h76543210);

    // MULDIV_EN=0: mul/div complete in one cycle as illegal
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sn_op = (k == 0) ? 3'd6 : 3'd5; sn_a = 8'h33; sn_b = 8'h05; sn_start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      sn_start = 1'b0;
      check("nodiv_done_cycle", {31'h0, donen}, 32'h1);
      check("nodiv_when", 32'(cyc - t0), 32'h1);
      check("nodiv_busy", {31'h0, busyn}, 32'h0);
      check("nodiv_result", {16'h0, resn, hin}, 32'h0);
      check("nodiv_illegal", {29'h0, illn, dbzn, ovfn}, 32'h4);
      @(negedge clk);
      check("nodiv_done_width", {30'h0, donen, busyn}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised execute-stage ALU: takes the 3-bit operation code produced by the ALU control decoder and computes the result.
- add, sub, and, or, slt and nop complete in one cycle.
- mul (shift-add) and div (restoring) are iterative and take WIDTH+1 cycles.
- Sits between the ALU control decoder and the pipeline/multicycle controller, which uses START/BUSY/DONE to stall while an iterative operation is in progress.

Parameters:
- WIDTH, 32: operand and result width; legal range 4..64.
- MULDIV_EN, 1: 1 instantiates the iterative mul/div datapath. 0 removes it; op codes 101 and 110 then complete in one cycle with RESULT=0 and ILLEGAL=1.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  request; sampled only while BUSY=0
- OP  in  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 nop
- A  in  WIDTH  operand A; captured when START is accepted
- B  in  WIDTH  operand B; captured when START is accepted
- BUSY  out  1  high while an iterative operation is in progress
- DONE  out  1  one-cycle pulse; RESULT, RESULT_HI and the flags are valid in this cycle
- RESULT  out  WIDTH  main result; low half of product for mul, quotient for div
- RESULT_HI  out  WIDTH  high half of product for mul, remainder for div, 0 for all other ops
- ZERO  out  1  RESULT==0; registered together with RESULT
- OVF  out  1  signed overflow for add/sub; 0 for all other ops
- DIV_BY_ZERO  out  1  set for div with B==0
- ILLEGAL  out  1  mul/div requested while MULDIV_EN=0

Behaviour:
- Reset (asynchronous, RST_N=0): state IDLE; all outputs 0; iteration counter 0; operand/accumulator registers 0. Applies immediately, including mid-operation; the in-flight operation is discarded and no DONE is issued.
- States: IDLE, MUL, DIV.
- START=1 in IDLE at cycle N: A, B and OP are captured. Operands are never re-read after capture.
- Single-cycle ops: result registered at edge N+1. DONE=1 and BUSY=0 during cycle N+1.
- Back-to-back single-cycle ops: a new START may be accepted in the same cycle as DONE.
- add/sub: modulo 2^WIDTH. OVF = signed overflow (operand signs equal for add, or differ for sub, and result sign differs from A).
- and/or: bitwise.
- slt: signed compare; RESULT = 1 if A<B, else 0.
- nop: RESULT=0, RESULT_HI=0, all flags 0, DONE still pulses.
- mul (MULDIV_EN=1): edge N+1 loads multiplicand, multiplier and a 2*WIDTH accumulator, sets counter=WIDTH, enters MUL; BUSY=1. One shift-add step per edge, counter decremented.
  - When counter reaches 0, return to IDLE: DONE=1, BUSY=0 in cycle N+WIDTH+1.
  - Unsigned: {RESULT_HI,RESULT} = A*B.
- div (MULDIV_EN=1, B!=0): same timing as mul using restoring division, one quotient bit per edge. Unsigned: RESULT=A/B, RESULT_HI=A%B.
- div with B==0: no iteration. DONE at cycle N+1, RESULT all ones, RESULT_HI=A, DIV_BY_ZERO=1, BUSY never asserted.
- START while BUSY=1: ignored; the running operation and captured operands are unaffected.
- Outputs between DONE pulses: RESULT, RESULT_HI and all flags hold their last values until the next DONE. DONE is exactly one cycle wide.
- Unknown/illegal OP values do not exist; all 8 codes are defined.

Test Plan:
- WIDTH=8, START with OP=000, A=0x7F, B=0x01 -> DONE next cycle, RESULT=0x80, OVF=1, ZERO=0; second START (OP=001, A=5, B=5) in the DONE cycle -> DONE next cycle, RESULT=0, ZERO=1.
- WIDTH=8, OP=100, A=0xFF, B=0x01 -> RESULT=1; swap operands -> RESULT=0.
- WIDTH=8, OP=101, A=200, B=3 -> BUSY high for 8 cycles, DONE in cycle N+9, RESULT=0x58, RESULT_HI=0x02; START pulses with other operands while BUSY -> ignored, same result.
- WIDTH=8, OP=110, A=100, B=7 -> DONE in cycle N+9, RESULT=14, RESULT_HI=2; then B=0, A=0x33 -> DONE in cycle N+1, RESULT=0xFF, RESULT_HI=0x33, DIV_BY_ZERO=1.
- WIDTH=32 mul, RST_N pulled low in cycle N+5 -> BUSY=0 and all outputs 0 asynchronously, no DONE; next START after release completes normally.
- MULDIV_EN=0, OP=110 -> DONE in cycle N+1, RESULT=0, ILLEGAL=1, BUSY never high.
